// File: rtl/cipher_pkg.sv
// Shared constants for the cipher channel arbiter: FSM encoding, op modes, byte width.
package cipher_pkg;

    localparam int DATA_W = 8;

    localparam logic MODE_ENC = 1'b0;  // data - key
    localparam logic MODE_DEC = 1'b1;  // data + key

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/cipher_channel_arbiter_if.sv
// Request/response/key bundle between the UART front ends and the cipher arbiter.
interface cipher_channel_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);
    import cipher_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_mode;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic [ID_W-1:0]           resp_id;
    logic                      resp_ready;
    logic                      key_wr;
    logic [DATA_W-1:0]         key_in;
    logic [DATA_W-1:0]         key_cur;
    logic                      busy;

    // Requester/consumer side.
    modport master (
        output req_valid, req_data, req_mode, resp_ready, key_wr, key_in,
        input  req_ack, resp_valid, resp_data, resp_id, key_cur, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_mode, resp_ready, key_wr, key_in,
        output req_ack, resp_valid, resp_data, resp_id, key_cur, busy
    );

endinterface

// File: rtl/cipher_channel_arbiter_rr_select.sv
// Combinational round-robin picker: first valid bit at or above ptr_i, wrapping at NUM_REQ.
module rr_select #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    // Walk NUM_REQ slots starting at ptr_i; the wrap is a subtract so non-power-of-two counts work.
    always_comb begin
        int          k;
        logic [ID_W-1:0] kk;
        k     = 0;
        kk    = '0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = int'(ptr_i) + off;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            kk = ID_W'(k);
            if (!any_o && valid_i[kk]) begin
                gnt_o[kk] = 1'b1;
                idx_o     = kk;
                any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cipher_channel_arbiter.sv
// Round-robin arbiter sharing one 8-bit add/subtract cipher and its key between requesters.
module cipher_channel_arbiter
    import cipher_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    cipher_channel_arbiter_if.slave  bus
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     op_id_q, op_id_d;
    logic [DATA_W-1:0]   op_data_q, op_data_d;
    logic [DATA_W-1:0]   op_key_q, op_key_d;
    logic                op_mode_q, op_mode_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]   key_q, key_d;
    logic [DATA_W-1:0]   pend_key_q, pend_key_d;
    logic                pend_vld_q, pend_vld_d;

    logic [NUM_REQ-1:0]  sel_gnt;
    logic [ID_W-1:0]     sel_idx;
    logic                sel_any;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_mode;
    logic                accept;

    rr_select #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_select (
        .valid_i (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (sel_gnt),
        .idx_o   (sel_idx),
        .any_o   (sel_any)
    );

    assign accept = (state_q == ST_DONE) && bus.resp_ready;

    // One-hot AND-OR mux of the granted requester's byte and mode.
    always_comb begin
        sel_data = '0;
        sel_mode = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_gnt[i]) begin
                sel_data = sel_data | bus.req_data[i*DATA_W +: DATA_W];
                sel_mode = sel_mode | bus.req_mode[i];
            end
        end
    end

    // Next-state: FSM sequencing, operand capture, cipher result and key/pending-key bookkeeping.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        op_id_d    = op_id_q;
        op_data_d  = op_data_q;
        op_key_d   = op_key_q;
        op_mode_d  = op_mode_q;
        res_d      = res_q;
        key_d      = key_q;
        pend_key_d = pend_key_q;
        pend_vld_d = pend_vld_q;

        case (state_q)
            ST_IDLE: begin
                // A grant on the same edge as a key write snapshots the old key.
                if (sel_any) begin
                    op_data_d = sel_data;
                    op_mode_d = sel_mode;
                    op_id_d   = sel_idx;
                    op_key_d  = key_q;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_EXEC;
            ST_EXEC: begin
                res_d   = (op_mode_q == MODE_DEC) ? op_data_q + op_key_q
                                                  : op_data_q - op_key_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.resp_ready) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (op_id_q == ID_W'(NUM_REQ - 1)) ? '0 : op_id_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Key writes land directly when idle; while busy they park in the pending slot
        // and get applied on the release edge, where a fresh write beats the parked one.
        if (state_q == ST_IDLE) begin
            if (bus.key_wr) key_d = bus.key_in;
        end else if (accept) begin
            if (bus.key_wr)      key_d = bus.key_in;
            else if (pend_vld_q) key_d = pend_key_q;
            pend_vld_d = 1'b0;
        end else if (bus.key_wr) begin
            pend_vld_d = 1'b1;
            pend_key_d = bus.key_in;
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            op_id_q    <= '0;
            op_data_q  <= '0;
            op_key_q   <= '0;
            op_mode_q  <= 1'b0;
            res_q      <= '0;
            key_q      <= '0;
            pend_key_q <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            op_id_q    <= op_id_d;
            op_data_q  <= op_data_d;
            op_key_q   <= op_key_d;
            op_mode_q  <= op_mode_d;
            res_q      <= res_d;
            key_q      <= key_d;
            pend_key_q <= pend_key_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // Acknowledge the captured requester for the single LOAD cycle.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ack[i] = (state_q == ST_LOAD) && (op_id_q == ID_W'(i));
        end
    end

    assign bus.resp_valid = (state_q == ST_DONE);
    assign bus.resp_data  = res_q;
    assign bus.resp_id    = op_id_q;
    assign bus.key_cur    = key_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cipher_channel_arbiter.sv
// Directed scoreboard bench for cipher_channel_arbiter (NUM_REQ = 2).
module tb_cipher_channel_arbiter;
    import cipher_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    cipher_channel_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    cipher_channel_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    exp_t       sbq[$];
    logic [7:0] key_m;
    int         rr_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic m, input logic [7:0] k);
        logic [7:0] r;
        r = (m == MODE_DEC) ? d + k : d - k;
        return r;
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] mask, input int ptr);
        for (int o = 0; o < NUM_REQ; o++) begin
            int j;
            j = (ptr + o) % NUM_REQ;
            if (mask[j]) return j;
        end
        return 0;
    endfunction

    task automatic chk_zero(input string pfx);
        chk({pfx, ".ack"},        32'(bus.req_ack),    0);
        chk({pfx, ".resp_valid"}, 32'(bus.resp_valid), 0);
        chk({pfx, ".resp_data"},  32'(bus.resp_data),  0);
        chk({pfx, ".resp_id"},    32'(bus.resp_id),    0);
        chk({pfx, ".busy"},       32'(bus.busy),       0);
        chk({pfx, ".key_cur"},    32'(bus.key_cur),    0);
    endtask

    // Pops the scoreboard and compares against the response currently presented.
    task automatic check_resp(input string tag, output exp_t e);
        e = 'x;
        if (sbq.size() > 0) e = sbq.pop_front();
        chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 1);
        chk({tag, ".resp_data"},  32'(bus.resp_data),  32'(e.data));
        chk({tag, ".resp_id"},    32'(bus.resp_id),    32'(e.id));
    endtask

    // One request from IDLE; optional key write on the grant edge; optional stall in DONE.
    task automatic txn(input string tag, input int id, input logic [7:0] d, input logic m,
                       input int stall, input logic kw, input logic [7:0] kv);
        exp_t e;
        bus.req_valid         = '0;
        bus.req_valid[id]     = 1'b1;
        bus.req_data[id*8 +: 8] = d;
        bus.req_mode[id]      = m;
        bus.key_wr            = kw;
        bus.key_in            = kv;
        sbq.push_back('{id: ID_W'(id), data: model(d, m, key_m)});
        tick();                                            // LOAD
        if (kw) key_m = kv;
        bus.key_wr = 1'b0;
        chk({tag, ".ack"},  32'(bus.req_ack), 32'(1 << id));
        chk({tag, ".busy"}, 32'(bus.busy),    1);
        bus.req_valid = '0;
        tick();                                            // EXEC
        chk({tag, ".exec_ack"},   32'(bus.req_ack),    0);
        chk({tag, ".exec_valid"}, 32'(bus.resp_valid), 0);
        tick();                                            // DONE
        check_resp(tag, e);
        for (int s = 0; s < stall; s++) begin
            bus.req_valid = ~(NUM_REQ'(1) << id);
            tick();
            chk({tag, ".stall_valid"}, 32'(bus.resp_valid), 1);
            chk({tag, ".stall_data"},  32'(bus.resp_data),  32'(e.data));
            chk({tag, ".stall_id"},    32'(bus.resp_id),    32'(e.id));
            chk({tag, ".stall_ack"},   32'(bus.req_ack),    0);
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        tick();                                            // accepted -> IDLE
        bus.resp_ready = 1'b0;
        chk({tag, ".idle_busy"},  32'(bus.busy),       0);
        chk({tag, ".idle_valid"}, 32'(bus.resp_valid), 0);
        rr_m = (id + 1) % NUM_REQ;
    endtask

    // Requesters in mask held valid with resp_ready high; grants must follow round-robin.
    task automatic stream(input string tag, input logic [NUM_REQ-1:0] mask, input int nresp);
        logic [7:0] dat [NUM_REQ];
        int   got;
        int   last;
        int   budget;
        exp_t e;
        dat[0] = 8'h3C;
        dat[1] = 8'hA1;
        got    = 0;
        last   = -1;
        budget = nresp * 4 + 10;
        bus.req_data   = {dat[1], dat[0]};
        bus.req_mode   = 2'b10;
        bus.req_valid  = mask;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < budget && got < nresp; c++) begin
            tick();
            if (bus.req_ack != '0) begin
                int p;
                p = pick(mask, rr_m);
                chk({tag, ".rr_ack"}, 32'(bus.req_ack), 32'(1 << p));
                sbq.push_back('{id: ID_W'(p), data: model(dat[p], bus.req_mode[p], key_m)});
            end
            if (bus.resp_valid) begin
                check_resp(tag, e);
                if (last >= 0) chk({tag, ".gap"}, 32'(cyc - last), 4);
                last = cyc;
                rr_m = (int'(e.id) + 1) % NUM_REQ;
                got++;
                if (got == nresp) bus.req_valid = '0;
            end
        end
        chk({tag, ".count"}, 32'(got), 32'(nresp));
        tick();
        bus.resp_ready = 1'b0;
        chk({tag, ".end_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        exp_t e;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_mode   = '0;
        bus.resp_ready = 1'b0;
        bus.key_wr     = 1'b0;
        bus.key_in     = '0;
        key_m          = 8'h00;
        rr_m           = 0;

        reset = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // Key write in IDLE then encrypt: 0x05 - 0x10 = 0xF5.
        bus.key_wr = 1'b1; bus.key_in = 8'h10;
        tick();
        bus.key_wr = 1'b0; key_m = 8'h10;
        chk("key_idle", 32'(bus.key_cur), 32'h10);
        txn("enc_wrap", 0, 8'h05, MODE_ENC, 0, 1'b0, 8'h00);

        // Decrypt with wrap: 0xF0 + 0x20 = 0x10 on requester 1.
        bus.key_wr = 1'b1; bus.key_in = 8'h20;
        tick();
        bus.key_wr = 1'b0; key_m = 8'h20;
        txn("dec_wrap", 1, 8'hF0, MODE_DEC, 0, 1'b0, 8'h00);

        // Key write on the grant edge: in-flight op uses the old key 0x20.
        txn("same_edge_key", 0, 8'h31, MODE_ENC, 0, 1'b1, 8'h77);
        chk("same_edge_key.key_cur", 32'(bus.key_cur), 32'h77);

        // Stall 5 cycles in DONE with the other requester waiting.
        txn("stall", 0, 8'h42, MODE_DEC, 5, 1'b0, 8'h00);

        // Pending key: 0x33 written in EXEC, 0x44 in DONE; result uses 0x01.
        bus.key_wr = 1'b1; bus.key_in = 8'h01;
        tick();
        bus.key_wr = 1'b0; key_m = 8'h01;
        bus.req_valid = 2'b10; bus.req_data[15:8] = 8'h80; bus.req_mode[1] = MODE_ENC;
        sbq.push_back('{id: 1'b1, data: model(8'h80, MODE_ENC, key_m)});
        tick();                                            // LOAD
        chk("pend.ack", 32'(bus.req_ack), 32'b10);
        bus.req_valid = '0;
        tick();                                            // EXEC
        bus.key_wr = 1'b1; bus.key_in = 8'h33;
        tick();                                            // DONE
        chk("pend.key_exec", 32'(bus.key_cur), 32'h01);
        bus.key_in = 8'h44;
        check_resp("pend", e);
        tick();                                            // still DONE
        bus.key_wr = 1'b0;
        chk("pend.key_done", 32'(bus.key_cur), 32'h01);
        chk("pend.hold",     32'(bus.resp_data), 32'(e.data));
        bus.resp_ready = 1'b1;
        tick();                                            // -> IDLE
        bus.resp_ready = 1'b0;
        chk("pend.key_applied", 32'(bus.key_cur), 32'h44);
        key_m = 8'h44; rr_m = 0;

        // Key write on the DONE->IDLE edge beats the parked pending value.
        bus.req_valid = 2'b10; bus.req_data[15:8] = 8'h50; bus.req_mode[1] = MODE_ENC;
        sbq.push_back('{id: 1'b1, data: model(8'h50, MODE_ENC, key_m)});
        tick();                                            // LOAD
        bus.req_valid = '0;
        bus.key_wr = 1'b1; bus.key_in = 8'h55;
        tick();                                            // EXEC
        bus.key_wr = 1'b0;
        tick();                                            // DONE
        check_resp("override", e);
        bus.resp_ready = 1'b1; bus.key_wr = 1'b1; bus.key_in = 8'h66;
        tick();
        bus.resp_ready = 1'b0; bus.key_wr = 1'b0;
        chk("override.key_cur", 32'(bus.key_cur), 32'h66);
        key_m = 8'h66; rr_m = 0;

        // Both requesters valid: strict 0,1,0,1 rotation, responses 4 cycles apart.
        stream("rotate", 2'b11, 6);
        // Only requester 1 valid: served every 4 cycles whatever the pointer.
        stream("single", 2'b10, 3);

        // Asynchronous reset while in EXEC drops the op and clears everything.
        bus.req_valid = 2'b01; bus.req_data[7:0] = 8'h11; bus.req_mode[0] = MODE_ENC;
        tick();                                            // LOAD
        bus.req_valid = '0;
        tick();                                            // EXEC
        chk("pre_reset.busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        tick();
        reset = 1'b0;
        key_m = 8'h00; rr_m = 0;
        txn("post_reset", 1, 8'h22, MODE_ENC, 0, 1'b0, 8'h00);

        chk("sb_drained", 32'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cipher_channel_arbiter.md
Name: cipher_channel_arbiter

Overview:
Shares one 8-bit subtract/add cipher datapath and its key register between NUM_REQ requesters. Each requester submits a byte with a mode bit: encrypt computes data - key, decrypt computes data + key. A round-robin FSM grants one request at a time and returns the result with the requester ID over a valid/ready response port. The block sits between the UART Tx/Rx front ends and the cipher, and owns all key updates.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ID_W, 1, width of requester index; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held high until the matching req_ack
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_mode  in  NUM_REQ  per-requester op: 0 = encrypt (data - key), 1 = decrypt (data + key)
req_ack  out  NUM_REQ  one-hot, one-cycle grant/capture acknowledge
resp_valid  out  1  result available
resp_data  out  8  result byte
resp_id  out  ID_W  index of the requester the result belongs to
resp_ready  in  1  consumer accepts the result
key_wr  in  1  key write strobe
key_in  in  8  new key value
key_cur  out  8  key currently in effect
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-high): all outputs and registers clear to 0.
  - Cleared: state = IDLE, rr_ptr = 0, key = 0, pending key valid = 0, pending key value = 0, operand/mode/id regs = 0.
  - Outputs: req_ack = 0, resp_valid = 0, resp_data = 0, resp_id = 0, busy = 0, key_cur = 0.
  - Reset mid-operation drops any in-flight request with no ack or response. A requester whose ack was already seen must not resend.
- FSM states: IDLE, LOAD, EXEC, DONE.
- IDLE:
  - If any req_valid is high, select the first set bit searching from rr_ptr upward with wrap-around.
  - On the clock edge, capture the selected requester's data, mode and index, plus the current key, then go to LOAD.
  - req_valid is ignored in all other states.
- LOAD (1 cycle): req_ack[sel] = 1, all other ack bits 0. Go to EXEC.
- EXEC (1 cycle): compute the result modulo 256 (8-bit wrap, no carry or borrow out) into resp_data, then go to DONE.
  - Example: 0x05 - 0x10 = 0xF5.
  - Example: 0xF0 + 0x20 = 0x10.
- DONE:
  - resp_valid = 1; resp_data and resp_id are held stable.
  - If resp_ready = 1 in a cycle, the response is accepted that cycle. Next state is IDLE and rr_ptr = (sel + 1) mod NUM_REQ.
  - resp_ready may already be high when DONE is entered; acceptance then happens in the first DONE cycle.
- Latency: req_valid high in IDLE at cycle t gives req_ack at t+1 and resp_valid at t+3. Minimum spacing between grants is 4 cycles.
- Key update rules:
  - key_wr in IDLE: key loads key_in at that edge. A request granted on the same edge uses the OLD key.
  - key_wr while busy: value is stored as pending (last write wins). Pending is applied on the DONE->IDLE edge, overriding the key without changing the in-flight result.
  - key_wr on the DONE->IDLE edge itself: key_in wins over the older pending value.
  - key_cur always shows the key register, never the pending value.
- Boundary conditions:
  - All requesters valid: strict rotation, with no requester served twice before each other valid requester is served once.
  - Single requester valid continuously: it is served every 4 cycles, regardless of rr_ptr.
  - NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0.

Decomposition:
- Shared package (cipher_pkg):
  - state encoding constants ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_EXEC = 2'd2, ST_DONE = 2'd3;
  - MODE_ENC = 1'b0, MODE_DEC = 1'b1;
  - DATA_W = 8.
- One sub-module: rr_select. It is combinational: it takes req_valid and rr_ptr and returns a one-hot grant plus an index and an any-valid flag. It is reused by other arbiters.
- The cipher arithmetic stays inline in the top module.

Test Plan:
- Reset, then key_wr with key_in = 0x10 in IDLE; req 0 encrypts 0x05 -> ack[0] one cycle later; resp_data = 0xF5, resp_id = 0 at t+3; key_cur = 0x10.
- Key 0x20; req 1 decrypts 0xF0 -> resp_data = 0x10, resp_id = 1; no carry output, no stray ack[0].
- Both requesters valid continuously with resp_ready tied to 1 -> grant order 0,1,0,1; each resp_valid asserted 4 cycles apart.
- Key 0x01; key_wr 0x33 in EXEC, then 0x44 in DONE while resp_ready = 0 -> in-flight result uses 0x01; key_cur = 0x44 after DONE->IDLE.
- resp_ready held 0 for 5 cycles in DONE -> resp_valid, resp_data and resp_id stable; no new ack issued; accepted on the first resp_ready = 1.
- Assert reset during EXEC -> all outputs 0 immediately (asynchronous); after release, a fresh request on req 1 is granted first (rr_ptr = 0, only req 1 valid).
